ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 tb/tb_ifetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one word fetch per PC value, holds the
// fetched word for decode until accepted, and reports misaligned or
// timed-out fetches. A redirect (flush) abandons whatever is in flight.
module ifetch_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] pc_addr,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        pc_hold,
   output logic        fetch_fault
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_imem_req;
   logic [XLEN-1:0]   r_imem_addr;
   logic [XLEN-1:0]   r_inst;
   logic [XLEN-1:0]   r_inst_pc;
   logic              r_inst_valid;
   logic              r_fetch_fault;
   logic [CNT_W-1:0]  r_cnt;

   state_t            w_state_nxt;
   logic              w_imem_req_nxt;
   logic [XLEN-1:0]   w_imem_addr_nxt;
   logic [XLEN-1:0]   w_inst_nxt;
   logic [XLEN-1:0]   w_inst_pc_nxt;
   logic              w_inst_valid_nxt;
   logic              w_fetch_fault_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_timeout;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // State and registered outputs; reset clears everything asynchronously
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= S_IDLE;
         r_imem_req    <= 1'b0;
         r_imem_addr   <= '0;
         r_inst        <= '0;
         r_inst_pc     <= '0;
         r_inst_valid  <= 1'b0;
         r_fetch_fault <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_imem_req    <= w_imem_req_nxt;
         r_imem_addr   <= w_imem_addr_nxt;
         r_inst        <= w_inst_nxt;
         r_inst_pc     <= w_inst_pc_nxt;
         r_inst_valid  <= w_inst_valid_nxt;
         r_fetch_fault <= w_fetch_fault_nxt;
         r_cnt         <= w_cnt_nxt;
      end
   end

   // Next-state and next-output logic; flush overrides every transition
   always_comb begin
      w_state_nxt       = r_state;
      w_imem_req_nxt    = r_imem_req;
      w_imem_addr_nxt   = r_imem_addr;
      w_inst_nxt        = r_inst;
      w_inst_pc_nxt     = r_inst_pc;
      w_inst_valid_nxt  = r_inst_valid;
      w_fetch_fault_nxt = r_fetch_fault;
      w_cnt_nxt         = r_cnt;

      if (flush) begin
         w_state_nxt       = S_IDLE;
         w_imem_req_nxt    = 1'b0;
         w_inst_valid_nxt  = 1'b0;
         w_fetch_fault_nxt = 1'b0;
         w_cnt_nxt         = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_imem_addr_nxt = pc_addr;
               w_inst_pc_nxt   = pc_addr;
               w_cnt_nxt       = '0;
               if (pc_addr[1:0] != 2'b00) begin
                  w_state_nxt       = S_FAULT;
                  w_fetch_fault_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_REQ;
                  w_imem_req_nxt = 1'b1;
               end
            end
            S_REQ: begin
               if (imem_ack) begin
                  w_inst_nxt       = imem_rdata;
                  w_inst_valid_nxt = 1'b1;
                  w_imem_req_nxt   = 1'b0;
                  w_state_nxt      = S_HOLD;
               end else if (w_timeout) begin
                  w_imem_req_nxt    = 1'b0;
                  w_fetch_fault_nxt = 1'b1;
                  w_state_nxt       = S_FAULT;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  w_inst_valid_nxt = 1'b0;
                  w_state_nxt      = S_IDLE;
               end
            end
            S_FAULT: begin
               w_state_nxt = S_FAULT;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_imem_addr;
   assign inst        = r_inst;
   assign inst_pc     = r_inst_pc;
   assign inst_valid  = r_inst_valid;
   assign fetch_fault = r_fetch_fault;

   // PC advances only in the decode handshake cycle or on a redirect
   assign pc_hold = ~flush & ~(r_inst_valid & inst_ready);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a PC model, a latency-randomised memory model and a
// scoreboard of expected (pc, word) pairs checked at each decode handshake.
module tb_ifetch_unit;

   localparam int unsigned TO = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] pc_addr = 32'h0;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        pc_hold;
   logic        fetch_fault;

   ifetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .pc_addr    (pc_addr),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .pc_hold    (pc_hold),
      .fetch_fault(fetch_fault)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_err = 0;
   int          req_cnt = 0;
   int          hs_cnt = 0;
   logic [31:0] pc = 32'h0;

   // memory model controls
   int          mem_lat = 0;      // -1 = random 0..3 wait cycles
   bit          mem_dead = 1'b0;
   bit          garbage = 1'b0;
   bit          force_en = 1'b0;
   logic [31:0] force_data = 32'h0;
   int          wait_left = -1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_pc();
      if (pc[1:0] == 2'b00) sb.push_back('{pc: pc, word: mem_word(pc)});
   endtask

   // Memory responder: acks after a per-request latency, junk acks when idle
   always @(negedge CLK) begin
      if (!imem_req) begin
         wait_left  = -1;
         imem_ack   = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
         imem_rdata = $urandom;
      end else begin
         if (wait_left < 0) wait_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
         if (!mem_dead && wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = force_en ? force_data : mem_word(imem_addr);
            wait_left  = -1;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (wait_left > 0) wait_left--;
         end
      end
   end

   // Monitor: scoreboard pop on handshake plus stability invariants
   logic        p_valid = 1'b0, p_ready = 1'b0, p_flush = 1'b0, p_req = 1'b0;
   logic [31:0] p_inst = 32'h0, p_pc = 32'h0, p_addr = 32'h0;
   always @(negedge CLK) begin
      #2;
      if (!RESET) begin
         p_valid = 1'b0;
         p_req   = 1'b0;
      end else begin
         if (imem_req) req_cnt++;
         if (p_req && imem_req) chk("imem_addr_stable", imem_addr, p_addr);
         if (p_valid && !p_ready && !p_flush) begin
            chk("inst_valid_held", 32'(inst_valid), 32'd1);
            chk("inst_stable", inst, p_inst);
            chk("inst_pc_stable", inst_pc, p_pc);
         end
         if (fetch_fault) chk("fault_quiet", {30'b0, imem_req, inst_valid}, 32'd0);
         if (inst_valid && inst_ready && !flush) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_inst: got pc 0x%08h with no fetch outstanding", inst_pc);
            end else begin
               mon_e = sb.pop_front();
               chk("inst", inst, mon_e.word);
               chk("inst_pc", inst_pc, mon_e.pc);
            end
         end
         p_valid = inst_valid; p_ready = inst_ready; p_flush = flush;
         p_req = imem_req; p_inst = inst; p_pc = inst_pc; p_addr = imem_addr;
      end
   end

   // One clock: drive inputs, check pc_hold, then model the PC register
   task automatic cyc(input bit fl, input bit rdy, input logic [31:0] tgt);
      logic [31:0] nxt;
      logic        exp_hold;
      @(negedge CLK);
      flush      = fl;
      inst_ready = rdy;
      #1;
      exp_hold = !fl && !(inst_valid && rdy);
      chk("pc_hold", 32'(pc_hold), 32'(exp_hold));
      nxt = fl ? tgt : (pc_hold ? pc : pc + 32'd4);
      @(posedge CLK);
      #1;
      if (fl) begin
         sb.delete();
         pc = nxt; pc_addr = pc; push_pc();
      end else if (nxt != pc) begin
         pc = nxt; pc_addr = pc; push_pc();
      end
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  r0, h0, n;
      bit  fl, rdy;

      // reset values
      repeat (2) @(posedge CLK);
      #3;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      chk("rst_pc_hold", 32'(pc_hold), 32'd1);
      flush = 1'b1;
      #1;
      chk("rst_pc_hold_flush", 32'(pc_hold), 32'd0);
      flush = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      pc = 32'h0; pc_addr = pc;
      sb.delete(); push_pc();

      // zero-wait fetch
      mem_lat = 0;
      cyc(0, 1, 0);
      chk("zw_req", 32'(imem_req), 32'd1);
      chk("zw_addr", imem_addr, 32'h0);
      chk("zw_valid_early", 32'(inst_valid), 32'd0);
      cyc(0, 1, 0);
      chk("zw_valid", 32'(inst_valid), 32'd1);
      chk("zw_inst", inst, 32'h0010_0093);
      chk("zw_inst_pc", inst_pc, 32'h0);
      chk("zw_pc_hold", 32'(pc_hold), 32'd0);
      cyc(0, 1, 0);
      chk("zw_valid_clear", 32'(inst_valid), 32'd0);
      chk("zw_pc_hold_back", 32'(pc_hold), 32'd1);
      chk("zw_pc_adv", pc, 32'h4);

      // wait states and backpressure
      mem_lat = 2; r0 = req_cnt;
      cyc(0, 0, 0);
      n = 0;
      while (!inst_valid && n < 10) begin cyc(0, 0, 0); n++; end
      chk("ws_valid", 32'(inst_valid), 32'd1);
      chk("ws_req_cycles", 32'(req_cnt - r0), 32'd3);
      repeat (2) begin
         cyc(0, 0, 0);
         chk("ws_hold_valid", 32'(inst_valid), 32'd1);
         chk("ws_pc_hold", 32'(pc_hold), 32'd1);
      end
      cyc(0, 1, 0);
      chk("ws_consumed", 32'(inst_valid), 32'd0);

      // misaligned address
      mem_lat = 0; r0 = req_cnt;
      cyc(1, 0, 32'h6);
      cyc(0, 0, 0);
      chk("mis_fault", 32'(fetch_fault), 32'd1);
      repeat (3) cyc(0, 1, 0);
      chk("mis_fault_held", 32'(fetch_fault), 32'd1);
      chk("mis_no_req", 32'(req_cnt - r0), 32'd0);
      cyc(1, 0, 32'h100);
      chk("mis_flush_clear", 32'(fetch_fault), 32'd0);
      chk("mis_imem_req", 32'(imem_req), 32'd0);

      // memory timeout
      mem_dead = 1'b1; r0 = req_cnt;
      cyc(0, 0, 0);
      n = 0;
      while (!fetch_fault && n < 40) begin cyc(0, 0, 0); n++; end
      chk("to_fault", 32'(fetch_fault), 32'd1);
      chk("to_req_cycles", 32'(req_cnt - r0), 32'(TO));
      chk("to_req_low", 32'(imem_req), 32'd0);
      mem_dead = 1'b0;
      cyc(1, 0, 32'h200);

      // flush coinciding with ack
      force_en = 1'b1; force_data = 32'hDEAD_BEEF;
      cyc(0, 0, 0);
      chk("fa_req", 32'(imem_req), 32'd1);
      cyc(1, 1, 32'h100);
      force_en = 1'b0;
      chk("fa_valid", 32'(inst_valid), 32'd0);
      chk("fa_req_drop", 32'(imem_req), 32'd0);
      cyc(0, 1, 0);
      chk("fa_addr", imem_addr, 32'h100);
      h0 = hs_cnt;
      repeat (3) cyc(0, 1, 0);
      chk("fa_fetched", 32'(hs_cnt - h0), 32'd1);

      // asynchronous reset pulse in the middle of a request
      mem_lat = 3;
      chk("ar_in_req", 32'(imem_req), 32'd1);
      #3;
      RESET = 1'b0;
      #1;
      chk("ar_req_drop", 32'(imem_req), 32'd0);
      chk("ar_valid_drop", 32'(inst_valid), 32'd0);
      pc = 32'h300; pc_addr = pc;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      sb.delete(); push_pc();
      h0 = hs_cnt; n = 0;
      while (hs_cnt == h0 && n < 12) begin cyc(0, 1, 0); n++; end
      chk("ar_refetch", 32'(hs_cnt - h0), 32'd1);

      // randomised traffic
      mem_lat = -1; garbage = 1'b1; h0 = hs_cnt;
      for (int i = 0; i < 500; i++) begin
         fl  = ($urandom_range(0, 99) < 4);
         rdy = ($urandom_range(0, 9) < 7);
         cyc(fl, rdy, 32'h1000 + 32'(4 * $urandom_range(0, 63)));
      end
      garbage = 1'b0;
      repeat (10) cyc(0, 1, 0);
      chk("rand_handshakes_min", 32'(hs_cnt - h0 >= 40), 32'd1);
      chk("rand_no_fault", 32'(fetch_fault), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
